// File: rtl/alu_cmd_engine.sv
// Command packet engine between UART RX and TX: parses opcode/length/payload
// packets and returns a 32-bit ADD or MUL result, or echoes the payload.
module alu_cmd_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  error_o
);
    typedef enum logic [2:0] {
        S_OPCODE, S_RSVD, S_LEN_LO, S_LEN_HI,
        S_OPERAND, S_ECHO, S_RESULT, S_DRAIN
    } state_t;

    localparam logic [7:0] OP_ADD  = 8'hA8;
    localparam logic [7:0] OP_MUL  = 8'h6A;
    localparam logic [7:0] OP_ECHO = 8'hEC;

    state_t               state_q, state_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [23:0]          opnd_q, opnd_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [31:0]          acc_q, acc_d;
    logic                 first_q, first_d;
    logic [1:0]           out_idx_q, out_idx_d;
    logic                 error_q, error_d;

    logic [LEN_WIDTH-1:0] len_w, rem_calc_w;
    logic [31:0]          opnd_full_w;
    logic                 is_arith_w, is_known_w, bad_len_w, reject_w;

    function automatic logic [31:0] acc_next(input logic        is_mul,
                                             input logic        first,
                                             input logic [31:0] acc,
                                             input logic [31:0] opnd);
        if (!is_mul) return acc + opnd;
        if (first)   return opnd;
        return acc * opnd;
    endfunction

    assign len_w       = LEN_WIDTH'({data_i, len_lo_q});
    assign rem_calc_w  = len_w - LEN_WIDTH'(4);
    assign opnd_full_w = {data_i, opnd_q};
    assign is_arith_w  = (opcode_q == OP_ADD) || (opcode_q == OP_MUL);
    assign is_known_w  = is_arith_w || (opcode_q == OP_ECHO);
    assign bad_len_w   = (len_w < LEN_WIDTH'(4));
    // Arithmetic payloads must be a non-empty whole number of 32-bit words.
    assign reject_w    = !is_known_w || bad_len_w ||
                         (is_arith_w && ((rem_calc_w == '0) || (rem_calc_w[1:0] != 2'b00)));
    assign error_o     = error_q;

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        len_lo_d   = len_lo_q;
        rem_d      = rem_q;
        opnd_d     = opnd_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        first_d    = first_q;
        out_idx_d  = out_idx_q;
        error_d    = 1'b0;
        ready_o    = 1'b1;
        valid_o    = 1'b0;
        data_o     = '0;

        case (state_q)
            S_OPCODE: if (valid_i) begin
                opcode_d = data_i;
                state_d  = S_RSVD;
            end
            S_RSVD: if (valid_i) state_d = S_LEN_LO;
            S_LEN_LO: if (valid_i) begin
                len_lo_d = data_i;
                state_d  = S_LEN_HI;
            end
            S_LEN_HI: if (valid_i) begin
                acc_d      = '0;
                first_d    = 1'b1;
                byte_cnt_d = '0;
                out_idx_d  = '0;
                rem_d      = bad_len_w ? '0 : rem_calc_w;
                if (reject_w) begin
                    error_d = 1'b1;
                    state_d = (bad_len_w || (rem_calc_w == '0)) ? S_OPCODE : S_DRAIN;
                end else if (rem_calc_w == '0) begin
                    state_d = S_OPCODE;
                end else begin
                    state_d = is_arith_w ? S_OPERAND : S_ECHO;
                end
            end
            S_OPERAND: if (valid_i) begin
                opnd_d     = opnd_full_w[31:8];
                byte_cnt_d = byte_cnt_q + 2'd1;
                rem_d      = rem_q - LEN_WIDTH'(1);
                if (byte_cnt_q == 2'd3) begin
                    acc_d   = acc_next(opcode_q == OP_MUL, first_q, acc_q, opnd_full_w);
                    first_d = 1'b0;
                end
                if (rem_q == LEN_WIDTH'(1)) state_d = S_RESULT;
            end
            S_ECHO: begin
                data_o  = data_i;
                valid_o = valid_i;
                ready_o = ready_i;
                if (valid_i && ready_i) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) state_d = S_OPCODE;
                end
            end
            S_RESULT: begin
                ready_o = 1'b0;
                valid_o = 1'b1;
                data_o  = acc_q[{out_idx_q, 3'b000} +: 8];
                if (ready_i) begin
                    out_idx_d = out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) state_d = S_OPCODE;
                end
            end
            S_DRAIN: if (valid_i) begin
                rem_d = rem_q - LEN_WIDTH'(1);
                if (rem_q == LEN_WIDTH'(1)) state_d = S_OPCODE;
            end
            default: state_d = S_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_OPCODE;
            opcode_q   <= '0;
            len_lo_q   <= '0;
            rem_q      <= '0;
            opnd_q     <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            first_q    <= 1'b1;
            out_idx_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            len_lo_q   <= len_lo_d;
            rem_q      <= rem_d;
            opnd_q     <= opnd_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            first_q    <= first_d;
            out_idx_q  <= out_idx_d;
            error_q    <= error_d;
        end
    end
endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
- Packet processor for the UART ALU path.
- Sits directly downstream of the UART receiver's byte stream and upstream of the UART transmitter.
- Parses command packets (opcode, reserved, 16-bit length, payload), computes add, multiply or echo, and streams the result bytes out.
- Both sides use valid/ready byte handshakes.

Parameters:
- DATA_WIDTH, 8, byte width of both streams; only 8 is supported.
- LEN_WIDTH, 16, width of the packet length field and the internal byte counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- data_i  input  DATA_WIDTH  inbound byte (from UART RX).
- valid_i  input  1  inbound byte valid.
- ready_o  output  1  engine accepts the inbound byte.
- data_o  output  DATA_WIDTH  outbound byte (to UART TX).
- valid_o  output  1  outbound byte valid.
- ready_i  input  1  downstream accepts the outbound byte.
- error_o  output  1  one-cycle pulse on a rejected packet.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: state=S_OPCODE, acc=0, counters=0, valid_o=0, data_o=0, error_o=0. ready_o is 1 after reset release.
- Handshakes:
  - An inbound transfer occurs on valid_i&&ready_o.
  - An outbound transfer occurs on valid_o&&ready_i.
  - Once raised, valid_o and data_o hold stable until the transfer completes.
- Packet format, in byte order: opcode, reserved (ignored), LEN low, LEN high, then LEN-4 payload bytes. LEN is the total byte count and includes the header.
- Opcodes:
  - 0xA8 = ADD32
  - 0x6A = MUL32
  - 0xEC = ECHO
- State machine:
  - S_OPCODE: latch opcode. Advance to S_RSVD.
  - S_RSVD: consume one byte. Advance to S_LEN_LO.
  - S_LEN_LO: latch low length byte. Advance to S_LEN_HI.
  - S_LEN_HI: latch high length byte and compute rem = LEN-4. Dispatch:
    - Opcode unknown, or LEN<4: error_o pulses next cycle. If rem>0 (LEN>=4), go to S_DRAIN; otherwise go to S_OPCODE.
    - ADD32/MUL32 with rem==0 or rem%4!=0: same error handling.
    - ECHO with rem==0: return to S_OPCODE with no output.
    - Otherwise: go to S_OPERAND (ADD32/MUL32) or S_ECHO (ECHO).
  - S_OPERAND:
    - Shift bytes into a 32-bit operand register, little-endian (first byte is bits 7:0).
    - On each 4th byte, update the accumulator:
      - ADD: acc = acc + operand, mod 2^32, starting from 0.
      - MUL: first operand loads acc; each later operand sets acc = acc*operand, lower 32 bits kept.
    - On the last payload byte, go to S_RESULT. The updated acc is visible in S_RESULT.
    - ready_o=1 throughout.
  - S_ECHO:
    - Combinational pass-through: data_o=data_i, valid_o=valid_i, ready_o=ready_i.
    - Decrement rem on each transfer. When rem reaches 0, go to S_OPCODE.
  - S_RESULT:
    - ready_o=0, valid_o=1.
    - Emit acc bytes in order 7:0, 15:8, 23:16, 31:24.
    - Advance one byte per outbound transfer. After the 4th byte, go to S_OPCODE with valid_o=0.
  - S_DRAIN: ready_o=1, data discarded, no output. Decrement rem per transfer. At 0, go to S_OPCODE.
- Latency:
  - First result byte: valid_o rises the cycle after the last operand byte is accepted.
  - ECHO: 0 cycles.
- error_o: exactly one clk_i cycle wide per rejected packet.
- Reset mid-packet: abandon all state immediately. The partial packet is forgotten, and any bytes still arriving are parsed as a new packet.
- Back-to-back packets: S_OPCODE accepts the next opcode the cycle after the previous packet completes.

Test Plan:
- ADD32: A8 00 0C 00 01 00 00 00 02 00 00 00 with ready_i=1 -> out 03 00 00 00, error_o=0.
- ADD32 wrap: A8 00 0C 00 FF FF FF FF 02 00 00 00 -> out 01 00 00 00.
- MUL32: 6A 00 10 00 03 00 00 00 05 00 00 00 00 00 01 00 -> out 00 00 0F 00 (0x000F0000). The result is held stable while ready_i is toggled every other cycle.
- ECHO: EC 00 07 00 61 62 63 with ready_i low for 3 cycles mid-stream -> out 61 62 63, no loss or duplicates, ready_o follows ready_i.
- Errors:
  - 55 00 06 00 AA BB -> error_o one pulse, AA BB drained, no output.
  - Then A8 00 08 00 07 00 00 00 -> out 07 00 00 00.
  - A8 00 06 00 11 22 -> error_o pulse, no output.
- Reset: assert rst_ni low while S_RESULT is holding byte 2 -> valid_o=0, error_o=0, and ready_o=1 after release. Then a fresh ADD of 04 00 00 00 -> out 04 00 00 00.
